// File: rtl/keccak_parse.sv
// Rejection-sampling parser: pulls 64-bit keccak words, splits each 3-byte group
// into two 12-bit candidates and emits those below Q as indexed coefficients.
module keccak_parse #(
    parameter int N_COEFF = 256,
    parameter int Q       = 3329
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] in_data,
    input  logic        in_ready,
    output logic        gimme,
    output logic [11:0] coeff,
    output logic        coeff_valid,
    input  logic        coeff_ready,
    output logic [7:0]  coeff_idx,
    output logic        busy,
    output logic        done,
    output logic [2:0]  dbg_state,
    output logic [3:0]  dbg_nbytes
);

    // Handshakes: a keccak word is consumed in any cycle where gimme is high
    // (gimme implies in_ready); a coefficient transfers on the rising edge where
    // coeff_valid & coeff_ready, and coeff/coeff_idx/coeff_valid hold until then.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_OUT1 = 3'd2,
        S_OUT2 = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [12:0] LP_Q = 13'(Q);
    localparam logic [8:0]  LP_N = 9'(N_COEFF);

    state_t      r_state;
    logic [79:0] r_buf;
    logic [3:0]  r_nbytes;
    logic [11:0] r_d2;
    logic [8:0]  r_count;
    logic [11:0] r_coeff;
    logic        r_coeff_valid;
    logic [7:0]  r_coeff_idx;

    logic        w_pop;
    logic        w_split;
    logic [79:0] w_shifted;
    logic        w_d1_ok;
    logic        w_d2_ok;
    logic [8:0]  w_count_inc;
    logic        w_last;
    logic        w_advance;

    // Oldest byte lives in r_buf[7:0], so d1 = {b1[3:0], b0} is r_buf[11:0]
    // and d2 = {b2, b1[7:4]} is r_buf[23:12].
    assign w_split     = (r_state == S_LOAD) && (r_nbytes >= 4'd3);
    assign w_pop       = (r_state == S_LOAD) && (r_nbytes < 4'd3) && in_ready;
    assign w_shifted   = {16'd0, in_data} << {r_nbytes, 3'b000};
    assign w_d1_ok     = {1'b0, r_buf[11:0]} < LP_Q;
    assign w_d2_ok     = {1'b0, r_d2} < LP_Q;
    assign w_count_inc = r_count + 9'd1;
    assign w_last      = (w_count_inc == LP_N);
    assign w_advance   = !r_coeff_valid || coeff_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_buf         <= '0;
            r_nbytes      <= '0;
            r_d2          <= '0;
            r_count       <= '0;
            r_coeff       <= '0;
            r_coeff_valid <= 1'b0;
            r_coeff_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_LOAD;
                        r_buf       <= '0;
                        r_nbytes    <= '0;
                        r_count     <= '0;
                        r_coeff_idx <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_split) begin
                        r_coeff       <= r_buf[11:0];
                        r_coeff_valid <= w_d1_ok;
                        r_coeff_idx   <= r_count[7:0];
                        r_d2          <= r_buf[23:12];
                        r_buf         <= r_buf >> 24;
                        r_nbytes      <= r_nbytes - 4'd3;
                        r_state       <= S_OUT1;
                    end else if (w_pop) begin
                        r_buf    <= r_buf | w_shifted;
                        r_nbytes <= r_nbytes + 4'd8;
                    end
                end
                S_OUT1: begin
                    // A rejected d1 just spends this one cycle with valid low.
                    if (w_advance) begin
                        if (r_coeff_valid && w_last) begin
                            r_count       <= w_count_inc;
                            r_coeff_valid <= 1'b0;
                            r_state       <= S_DONE;
                        end else begin
                            if (r_coeff_valid) begin
                                r_count     <= w_count_inc;
                                r_coeff_idx <= w_count_inc[7:0];
                            end
                            r_coeff       <= r_d2;
                            r_coeff_valid <= w_d2_ok;
                            r_state       <= S_OUT2;
                        end
                    end
                end
                S_OUT2: begin
                    if (w_advance) begin
                        if (r_coeff_valid) begin
                            r_count <= w_count_inc;
                        end
                        r_coeff_valid <= 1'b0;
                        r_state       <= (r_coeff_valid && w_last) ? S_DONE : S_LOAD;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gimme       = w_pop;
    assign coeff       = r_coeff;
    assign coeff_valid = r_coeff_valid;
    assign coeff_idx   = r_coeff_idx;
    assign busy        = (r_state == S_LOAD) || (r_state == S_OUT1) || (r_state == S_OUT2);
    assign done        = (r_state == S_DONE);
    assign dbg_state   = r_state;
    assign dbg_nbytes  = r_nbytes;

endmodule

// File: tb/tb_keccak_parse.sv
// Bench for keccak_parse: a byte-level reference model fills an expected queue per
// run, a negedge monitor pops it on every coefficient handshake.
`timescale 1ns/1ps
module tb_keccak_parse;

    localparam int N_COEFF = 256;
    localparam int Q       = 3329;
    localparam int ST_LOAD = 1;
    localparam int ST_OUT2 = 3;
    localparam int ST_DONE = 4;
    localparam int MAX_WAIT = 20000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_ready = 1'b0;
    logic        gimme;
    logic [11:0] coeff;
    logic        coeff_valid;
    logic        coeff_ready = 1'b0;
    logic [7:0]  coeff_idx;
    logic        busy;
    logic        done;
    logic [2:0]  dbg_state;
    logic [3:0]  dbg_nbytes;

    keccak_parse #(.N_COEFF(N_COEFF), .Q(Q)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .gimme       (gimme),
        .coeff       (coeff),
        .coeff_valid (coeff_valid),
        .coeff_ready (coeff_ready),
        .coeff_idx   (coeff_idx),
        .busy        (busy),
        .done        (done),
        .dbg_state   (dbg_state),
        .dbg_nbytes  (dbg_nbytes)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [19:0] exp_q[$];      // {idx, coeff}
    logic [63:0] stream_q[$];
    logic [63:0] fifo_q[$];
    logic [7:0]  byte_q[$];
    int          exp_pops;
    int          exp_left;

    int   in_rdy_pct  = 100;
    int   rdy_pct     = 100;
    int   hold_cnt    = 0;
    logic pop_pending = 1'b0;
    int   gimme_cnt   = 0;
    int   hs_cnt      = 0;
    int   cyc         = 0;
    int   start_cyc   = 0;
    int   first_gimme = -1;
    int   first_valid = -1;

    logic        prev_hold = 1'b0;
    logic [11:0] prev_coeff;
    logic [7:0]  prev_idx;
    logic [2:0]  prev_state;
    logic [19:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- drivers: keccak FIFO and downstream ready ----------------
    always @(posedge clk) begin
        #1;
        if (pop_pending && fifo_q.size() > 0) fifo_q.delete(0);
        pop_pending = 1'b0;
        in_data  = (fifo_q.size() > 0) ? fifo_q[0] : 64'd0;
        in_ready = (fifo_q.size() > 0) && (int'($urandom_range(0, 99)) < in_rdy_pct);
        if (hold_cnt > 0) begin
            coeff_ready = 1'b0;
            if (coeff_valid) hold_cnt--;
        end else begin
            coeff_ready = (int'($urandom_range(0, 99)) < rdy_pct);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            prev_hold   = 1'b0;
            pop_pending = 1'b0;
        end else begin
            if (start) begin
                start_cyc   = cyc;
                first_gimme = -1;
                first_valid = -1;
            end
            if (gimme) begin
                gimme_cnt++;
                pop_pending = 1'b1;
                if (first_gimme < 0) first_gimme = cyc;
                check("gimme_legal", {29'd0, in_ready, dbg_state == 3'(ST_LOAD), dbg_nbytes < 4'd3}, 32'd7);
            end
            if (coeff_valid && first_valid < 0) first_valid = cyc;
            if (prev_hold) begin
                check("hold_valid", {31'd0, coeff_valid}, 32'd1);
                check("hold_coeff", {20'd0, coeff}, {20'd0, prev_coeff});
                check("hold_idx", {24'd0, coeff_idx}, {24'd0, prev_idx});
                check("hold_state", {29'd0, dbg_state}, {29'd0, prev_state});
            end
            if (coeff_valid && coeff_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL coeff_unexpected: actual idx %0d coeff %0d required none", coeff_idx, coeff);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("coeff", {20'd0, coeff}, {20'd0, mon_e[11:0]});
                    check("coeff_idx", {24'd0, coeff_idx}, {24'd0, mon_e[19:12]});
                end
            end
            prev_hold  = coeff_valid && !coeff_ready;
            prev_coeff = coeff;
            prev_idx   = coeff_idx;
            prev_state = dbg_state;
        end
    end

    // ---------------- reference model ----------------
    // Walk the byte stream in triples; accept candidates < Q until N_COEFF.
    task automatic build_model();
        int acc;
        int t;
        int b0, b1, b2, c1, c2;
        logic [63:0] w;
        byte_q.delete();
        exp_q.delete();
        foreach (stream_q[i]) begin
            w = stream_q[i];
            for (int k = 0; k < 8; k++) byte_q.push_back(w[8*k +: 8]);
        end
        acc = 0;
        t   = 0;
        while (acc < N_COEFF) begin
            if (3 * t + 2 >= byte_q.size()) begin
                n_checks++;
                n_fail++;
                $display("FAIL model_stream: actual %0d bytes required more", byte_q.size());
                break;
            end
            b0 = int'(byte_q[3*t]);
            b1 = int'(byte_q[3*t+1]);
            b2 = int'(byte_q[3*t+2]);
            c1 = b0 + 256 * (b1 % 16);
            c2 = b1 / 16 + 16 * b2;
            if (c1 < Q) begin
                exp_q.push_back({8'(acc), 12'(c1)});
                acc++;
            end
            if (acc < N_COEFF && c2 < Q) begin
                exp_q.push_back({8'(acc), 12'(c2)});
                acc++;
            end
            t++;
        end
        exp_pops = (3 * t + 7) / 8;
        exp_left = exp_pops * 8 - 3 * t;
    endtask

    // ---------------- stimulus tasks ----------------
    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_stream(input string name, input bit timing_chk);
        int waited;
        build_model();
        @(negedge clk);
        fifo_q    = stream_q;
        gimme_cnt = 0;
        pulse_start();
        waited = 0;
        while (!done && waited < MAX_WAIT) begin
            @(negedge clk);
            waited++;
        end
        repeat (5) @(negedge clk);
        check({name, "_timeout"}, {31'd0, waited < MAX_WAIT}, 32'd1);
        check({name, "_exp_left"}, exp_q.size(), 32'd0);
        check({name, "_gimme_cnt"}, gimme_cnt, exp_pops);
        check({name, "_nbytes"}, {28'd0, dbg_nbytes}, exp_left);
        check({name, "_done_busy_valid"}, {29'd0, done, busy, coeff_valid}, 32'd4);
        check({name, "_state"}, {29'd0, dbg_state}, ST_DONE);
        if (timing_chk) begin
            check({name, "_start_to_gimme"}, first_gimme - start_cyc, 32'd1);
            check({name, "_pop_to_valid"}, first_valid - first_gimme, 32'd2);
        end
    endtask

    task automatic random_stream(input int n_words);
        stream_q.delete();
        for (int i = 0; i < n_words; i++) stream_q.push_back({$urandom, $urandom});
    endtask

    task automatic zero_pad(input int n_words);
        for (int i = 0; i < n_words; i++) stream_q.push_back(64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int waited;
        repeat (3) @(posedge clk);
        #1;
        check("rst_coeff", {20'd0, coeff}, 32'd0);
        check("rst_valid", {31'd0, coeff_valid}, 32'd0);
        check("rst_idx", {24'd0, coeff_idx}, 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("rst_gimme", {31'd0, gimme}, 32'd0);
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // first word 0x030201 -> 513, 48, with an early 5-cycle backpressure hold
        in_rdy_pct = 100;
        rdy_pct    = 100;
        hold_cnt   = 5;
        stream_q.delete();
        stream_q.push_back(64'h0000_0000_0003_0201);
        zero_pad(50);
        run_stream("direct", 1'b1);

        // bound: 00 0D 00 | 01 0D 00 | FF FF FF
        stream_q.delete();
        stream_q.push_back(64'hFFFF_000D_0100_0D00);
        stream_q.push_back(64'h0000_0000_0000_00FF);
        zero_pad(50);
        run_stream("bound", 1'b1);

        // straddling triple {07, 08, 09}
        stream_q.delete();
        stream_q.push_back(64'h0807_0605_0403_0201);
        stream_q.push_back(64'h0000_0000_0000_0009);
        zero_pad(50);
        run_stream("straddle", 1'b1);

        // all-zero stream: 48 pops, nothing left over
        stream_q.delete();
        zero_pad(60);
        run_stream("zero", 1'b1);

        // random streams with random FIFO gaps and downstream stalls
        in_rdy_pct = 60;
        rdy_pct    = 60;
        for (int r = 0; r < 3; r++) begin
            random_stream(128);
            run_stream("rand", 1'b0);
        end
        rdy_pct = 20;
        random_stream(128);
        run_stream("rand_bp", 1'b0);

        // asynchronous reset while in OUT2 mid-run
        rdy_pct = 70;
        random_stream(128);
        build_model();
        @(negedge clk);
        fifo_q = stream_q;
        hs_cnt = 0;
        pulse_start();
        waited = 0;
        while (!(dbg_state == 3'(ST_OUT2) && hs_cnt >= 4) && waited < MAX_WAIT) begin
            @(negedge clk);
            waited++;
        end
        check("mid_reach_out2", {31'd0, waited < MAX_WAIT}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_coeff", {20'd0, coeff}, 32'd0);
        check("mid_rst_valid_busy_done", {29'd0, coeff_valid, busy, done}, 32'd0);
        check("mid_rst_idx", {24'd0, coeff_idx}, 32'd0);
        check("mid_rst_state_nbytes", {25'd0, dbg_state, dbg_nbytes}, 32'd0);
        exp_q.delete();
        fifo_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_gimme", {31'd0, gimme}, 32'd0);
        end
        @(negedge clk);
        #1 rst = 1'b1;
        in_rdy_pct = 100;
        rdy_pct    = 100;
        random_stream(128);
        run_stream("after_rst", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keccak_parse.md
# keccak_parse

Rejection-sampling parser at the squeeze end of the keccak core. It pulls 64-bit words from the keccak output FIFO with the `gimme`/`out_ready` handshake and splits the byte stream into 3-byte groups. Each group yields two 12-bit candidates, and candidates below Q are emitted as polynomial coefficients until N_COEFF are accepted. It is the reader for the keccak output interface and feeds the polynomial memory/NTT path.

## Interface
- N_COEFF, 256, accepted coefficients per run (≤256)
- Q, 3329, rejection bound; a candidate is accepted iff it is < Q
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low (asserted when 0)
- start  input  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE
- in_data  input  64  keccak output word (FIFO head); byte k = in_data[8k+7:8k]
- in_ready  input  1  keccak FIFO non-empty; in_data is valid while it is high
- gimme  output  1  pop strobe to the keccak FIFO; the word is consumed in the same cycle
- coeff  output  12  coefficient value, registered
- coeff_valid  output  1  coeff is valid
- coeff_ready  input  1  downstream accepts; handshake = coeff_valid & coeff_ready
- coeff_idx  output  8  index of the coefficient currently presented (0..N_COEFF-1)
- busy  output  1  high in LOAD/OUT1/OUT2
- done  output  1  high in DONE

## Operation
- Byte buffer: 80 bits plus `nbytes` (0..10). Byte 0 is the oldest byte and sits in buf[7:0].
- States are IDLE, LOAD, OUT1, OUT2 and DONE.
- IDLE / DONE
  - On `start`: clear `nbytes`, clear the accepted count and `coeff_idx`, then go to LOAD.
  - Bytes left over from a previous run are discarded.
- LOAD with `nbytes` < 3
  - `gimme` = `in_ready` (combinational).
  - On a pop: buf |= in_data << (8·nbytes), and nbytes += 8.
  - With `nbytes` < 3 the result never exceeds 10 bytes.
- LOAD with `nbytes` ≥ 3
  - No pop.
  - Latch d1 = {b1[3:0], b0} and d2 = {b2, b1[7:4]}.
  - Shift buf right 24 bits, nbytes -= 3, then go to OUT1.
- OUT1: present d1.
  - If d1 < Q: `coeff_valid` = 1, held until the handshake.
  - If d1 ≥ Q: `coeff_valid` = 0 for exactly one cycle, then go to OUT2.
  - On the handshake: count += 1. If count reaches N_COEFF go to DONE, else go to OUT2.
- OUT2: same as OUT1 but with d2. It exits to LOAD, or to DONE when count reaches N_COEFF.
- `coeff`, `coeff_idx` and `coeff_valid` stay stable while `coeff_valid` = 1 and `coeff_ready` = 0.
- `coeff_idx` = the accepted count at presentation time.
- `start` outside IDLE/DONE is ignored.
- Candidates remaining after the N_COEFF-th acceptance are dropped; d2 is not emitted if d1 completed the run.
- The keccak stream is treated as continuous. Block boundaries and word boundaries inside a triple are transparent.

## Timing
- All outputs are reset to 0 and the state to IDLE.
  - Reset is asynchronous and takes effect mid-run.
  - Buffered bytes and the count are lost.
  - No `gimme` is issued while `rst` = 0.
- `start` is sampled at cycle t. LOAD is active at t+1, and `gimme` may assert at t+1 if `in_ready`.
- Pop at cycle p → split at p+1 → first `coeff_valid` at p+2 (best case).
- Each subsequent triple, with no stall and no pop: LOAD → OUT1 → OUT2, i.e. 3 cycles per 2 candidates.
- `gimme` is never high outside LOAD, never high with `nbytes` ≥ 3, and never high with `in_ready` = 0.
- `coeff_valid` never drops without a handshake.
- The accepted count never exceeds N_COEFF.
- `done` stays high until `start` or reset.

## Test plan
- Word 0x0000_0000_0003_0201 after `start` → coeff 513 (idx 0), then 48 (idx 1); exactly one `gimme`.
- Bound check, bytes 00 0D 00 → 3328 accepted. Bytes 01 0D 00 → d1 = 3329 rejected, d2 = 0 accepted. Bytes FF FF FF → no `coeff_valid`; one bubble cycle in OUT1 and one in OUT2.
- Straddle: word0 bytes 00..07 = 0x01..0x08, word1 byte0 = 0x09. The third triple {07, 08, 09} → d1 = 0x807 = 2055, d2 = 0x090 = 144. The second `gimme` occurs with `nbytes` = 2.
- Backpressure: `coeff_ready` = 0 for 5 cycles during OUT1 → `coeff`/`coeff_idx` held constant, no `gimme`, no state advance. Release → single handshake.
- Full run on an all-zero stream → 256 zero coefficients, idx 0..255. Exactly 48 `gimme` pulses, `done` after the 256th handshake, `nbytes` = 0, no further `gimme`. A subsequent `start` restarts with idx 0.
- `rst` = 0 in OUT2 mid-run → all outputs 0 immediately. A new `start` after release → idx restarts at 0 from fresh words.
